// File: rtl/wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// npc_wb_pkg : shared definitions for the NPC writeback stage.
//   XLEN               data / address width
//   WB_*               writeback-source select encodings
//   LB..LHU            load funct3 encodings
//   wb_state_e         writeback FSM state encoding
//   load_fault_chk()   misalignment / illegal-width check for loads
// ---------------------------------------------------------------------------
package npc_wb_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] WB_MEM = 2'b00;
   localparam logic [1:0] WB_PC4 = 2'b01;
   localparam logic [1:0] WB_ALU = 2'b10;
   localparam logic [1:0] WB_IMM = 2'b11;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_MEM_REQ  = 2'b01,
      ST_MEM_WAIT = 2'b10,
      ST_WRITE    = 2'b11
   } wb_state_e;

   // A load faults when its width is not a legal load width, or when the
   // byte offset is not a multiple of the access size.
   function automatic logic load_fault_chk(input logic [2:0] f3,
                                           input logic [1:0] off);
      logic f;
      case (f3)
         LB, LBU: f = 1'b0;
         LH, LHU: f = off[0];
         LW:      f = (off != 2'b00);
         default: f = 1'b1;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/wb_stage_if.sv
// ---------------------------------------------------------------------------
// wb_stage_if : bundles the upstream retire handshake, the load memory port
// and the register-file write port of the writeback stage.
//
// Handshakes (in_valid/in_ready, mem_req_valid/mem_req_ready): a transfer
// happens on a rising edge where both valid and ready are high; once raised,
// the valid side holds valid and its payload stable until that edge.
// mem_resp_valid has no back-pressure: the stage captures it only while it is
// waiting for a response.
//
// Modports:
//   slave  - the writeback stage itself
//   master - the environment (upstream decode, memory, register file)
// ---------------------------------------------------------------------------
interface wb_stage_if;
   import npc_wb_pkg::*;

   // upstream retire port
   logic            in_valid;
   logic            in_ready;
   logic            reg_write;
   logic [1:0]      wb_sel;
   logic [4:0]      rd;
   logic [2:0]      funct3;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] imm_ext;

   // load memory port
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [XLEN-1:0] mem_addr;
   logic            mem_resp_valid;
   logic [XLEN-1:0] mem_resp_data;

   // register-file write port and status
   logic            rf_wen;
   logic [4:0]      rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic            wb_done;
   logic            load_fault;

   modport slave (
      input  in_valid, reg_write, wb_sel, rd, funct3, pc, alu_result, imm_ext,
      input  mem_req_ready, mem_resp_valid, mem_resp_data,
      output in_ready, mem_req_valid, mem_addr,
      output rf_wen, rf_waddr, rf_wdata, wb_done, load_fault
   );

   modport master (
      output in_valid, reg_write, wb_sel, rd, funct3, pc, alu_result, imm_ext,
      output mem_req_ready, mem_resp_valid, mem_resp_data,
      input  in_ready, mem_req_valid, mem_addr,
      input  rf_wen, rf_waddr, rf_wdata, wb_done, load_fault
   );

endinterface

// File: rtl/wb_stage_load_extend.sv
// ---------------------------------------------------------------------------
// load_extend : combinational lane select and sign/zero extension of a loaded
// word.
//   word_i    read word from memory
//   offset_i  byte offset of the access inside the word
//   funct3_i  load width/sign encoding
//   data_o    extended XLEN result (0 for an illegal funct3)
// ---------------------------------------------------------------------------
module load_extend
   import npc_wb_pkg::*;
(
   input  logic [XLEN-1:0] word_i,
   input  logic [1:0]      offset_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (offset_i)
         2'd0: byte_sel = word_i[7:0];
         2'd1: byte_sel = word_i[15:8];
         2'd2: byte_sel = word_i[23:16];
         2'd3: byte_sel = word_i[31:24];
         default: byte_sel = 8'h00;
      endcase
      // Halfword lane is chosen by offset bit 1 only; bit 0 is a fault case.
      half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

      data_o = '0;
      case (funct3_i)
         LB:  data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         LBU: data_o = {{(XLEN-8){1'b0}}, byte_sel};
         LH:  data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
         LHU: data_o = {{(XLEN-16){1'b0}}, half_sel};
         LW:  data_o = word_i;
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage : writeback stage of the NPC core. Accepts one retiring
// instruction at a time, fetches load data over the memory port when the
// source select is memory, and issues a single registered register-file
// write, with completion and load-fault pulses.
//   clk          core clock
//   rst_n        asynchronous active-low reset
//   bus          wb_stage_if.slave (retire, memory and rf-write ports)
//   dbg_state_o  current FSM state, for observation only
// ---------------------------------------------------------------------------
module wb_stage
   import npc_wb_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   wb_stage_if.slave     bus,
   output wb_state_e     dbg_state_o
);

   wb_state_e       state_q;
   logic            reg_write_q;
   logic [4:0]      rd_q;
   logic [2:0]      funct3_q;
   logic [1:0]      off_q;
   logic [XLEN-1:0] mem_addr_q;
   logic            mem_req_valid_q;
   logic            rf_wen_q;
   logic [4:0]      rf_waddr_q;
   logic [XLEN-1:0] rf_wdata_q;
   logic            wb_done_q;
   logic            load_fault_q;

   logic            accept_d;
   logic            fault_d;
   logic [XLEN-1:0] src_d;
   logic [XLEN-1:0] ext_d;

   load_extend u_load_extend (
      .word_i   (bus.mem_resp_data),
      .offset_i (off_q),
      .funct3_i (funct3_q),
      .data_o   (ext_d)
   );

   always_comb begin
      accept_d = bus.in_valid && (state_q == ST_IDLE);
      fault_d  = load_fault_chk(bus.funct3, bus.alu_result[1:0]);
      src_d    = '0;
      case (bus.wb_sel)
         WB_PC4:  src_d = bus.pc + XLEN'(4);  // wraps modulo 2^XLEN
         WB_ALU:  src_d = bus.alu_result;
         WB_IMM:  src_d = bus.imm_ext;
         default: src_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         reg_write_q     <= 1'b0;
         rd_q            <= '0;
         funct3_q        <= '0;
         off_q           <= '0;
         mem_addr_q      <= '0;
         mem_req_valid_q <= 1'b0;
         rf_wen_q        <= 1'b0;
         rf_waddr_q      <= '0;
         rf_wdata_q      <= '0;
         wb_done_q       <= 1'b0;
         load_fault_q    <= 1'b0;
      end else begin
         // Write-port outputs and status pulses live for the WRITE cycle only.
         rf_wen_q     <= 1'b0;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
         wb_done_q    <= 1'b0;
         load_fault_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (accept_d) begin
                  reg_write_q <= bus.reg_write;
                  rd_q        <= bus.rd;
                  funct3_q    <= bus.funct3;
                  off_q       <= bus.alu_result[1:0];
                  mem_addr_q  <= {bus.alu_result[XLEN-1:2], 2'b00};
                  if (bus.wb_sel != WB_MEM) begin
                     state_q    <= ST_WRITE;
                     rf_wen_q   <= bus.reg_write && (bus.rd != 5'd0);
                     rf_waddr_q <= bus.rd;
                     rf_wdata_q <= src_d;
                     wb_done_q  <= 1'b1;
                  end else if (fault_d) begin
                     // Faulted load: complete immediately, no request, no write.
                     state_q      <= ST_WRITE;
                     rf_waddr_q   <= bus.rd;
                     wb_done_q    <= 1'b1;
                     load_fault_q <= 1'b1;
                  end else begin
                     state_q         <= ST_MEM_REQ;
                     mem_req_valid_q <= 1'b1;
                  end
               end
            end

            ST_MEM_REQ: begin
               if (bus.mem_req_ready) begin
                  state_q         <= ST_MEM_WAIT;
                  mem_req_valid_q <= 1'b0;
               end
            end

            ST_MEM_WAIT: begin
               if (bus.mem_resp_valid) begin
                  state_q    <= ST_WRITE;
                  rf_wen_q   <= reg_write_q && (rd_q != 5'd0);
                  rf_waddr_q <= rd_q;
                  rf_wdata_q <= ext_d;
                  wb_done_q  <= 1'b1;
               end
            end

            ST_WRITE: begin
               state_q <= ST_IDLE;
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready      = (state_q == ST_IDLE);
   assign bus.mem_req_valid = mem_req_valid_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.rf_wen        = rf_wen_q;
   assign bus.rf_waddr      = rf_waddr_q;
   assign bus.rf_wdata      = rf_wdata_q;
   assign bus.wb_done       = wb_done_q;
   assign bus.load_fault    = load_fault_q;
   assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage : self-checking bench for wb_stage. Inputs change on the falling
// edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_wb_stage;
   import npc_wb_pkg::*;

   logic      clk = 1'b0;
   logic      rst_n;
   wb_state_e dbg_state;

   wb_stage_if bus();

   wb_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] exp_q[$];

   // observations filled by drive_instr
   int          o_done_cyc;
   logic        o_wen, o_fault, o_ready_at_done, o_ready_after;
   logic [4:0]  o_waddr;
   logic [31:0] o_wdata, o_addr;
   int          o_req_seen;
   bit          o_addr_unstable, o_early_wen;
   longint      o_accept_time;

   // Reference: result of one instruction computed from the architectural
   // rules (pc+4 wrap, lane shift, mask, two's-complement extension).
   function automatic void ref_model(input logic [1:0] sel, input logic [2:0] f3,
                                     input logic [31:0] pc, input logic [31:0] alu,
                                     input logic [31:0] imm, input logic [31:0] word,
                                     output logic [31:0] data, output bit fault);
      longint v, span;
      int off, size;
      data  = 32'h0;
      fault = 0;
      case (sel)
         2'd1: data = pc + 32'd4;
         2'd2: data = alu;
         2'd3: data = imm;
         default: begin
            off  = int'(alu % 4);
            size = (f3 == 3'd0 || f3 == 3'd4) ? 1 :
                   (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 0;
            if (size == 0 || (off % size) != 0) fault = 1;
            else begin
               span = longint'(1) << (8 * size);
               v    = ({32'd0, word} >> (8 * off)) % span;
               if (f3 < 3'd4 && v >= span / 2) v = v - span;
               data = v[31:0];
            end
         end
      endcase
   endfunction

   function automatic int exp_latency(input logic [1:0] sel, input bit fault,
                                      input int req_delay, input int resp_delay);
      if (sel != 2'd0 || fault) return 1;
      return 2 + req_delay + resp_delay;
   endfunction

   task automatic idle_inputs();
      bus.in_valid       = 1'b0;
      bus.reg_write      = 1'b0;
      bus.wb_sel         = 2'd0;
      bus.rd             = 5'd0;
      bus.funct3         = 3'd0;
      bus.pc             = 32'h0;
      bus.alu_result     = 32'h0;
      bus.imm_ext        = 32'h0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = 32'h0;
   endtask

   // Drives one instruction and plays the memory. req_delay = cycles
   // mem_req_ready stays low while requested; resp_delay = cycles from the
   // request handshake to the response (>= 1). With noise, ignored memory
   // inputs toggle randomly where they must have no effect.
   task automatic drive_instr(input logic wr, input logic [1:0] sel, input logic [4:0] rd,
                              input logic [2:0] f3, input logic [31:0] pc,
                              input logic [31:0] alu, input logic [31:0] imm,
                              input logic [31:0] word, input int req_delay,
                              input int resp_delay, input bit noise);
      int req_cnt, hs_cyc;
      bit hs;
      for (int w = 0; w < 20 && bus.in_ready !== 1'b1; w++) @(negedge clk);
      bus.in_valid   = 1'b1;
      bus.reg_write  = wr;
      bus.wb_sel     = sel;
      bus.rd         = rd;
      bus.funct3     = f3;
      bus.pc         = pc;
      bus.alu_result = alu;
      bus.imm_ext    = imm;
      @(negedge clk);
      o_accept_time  = longint'($time);
      bus.in_valid   = 1'b0;
      bus.reg_write  = 1'($urandom);
      bus.wb_sel     = 2'($urandom);
      bus.rd         = 5'($urandom);
      bus.funct3     = 3'($urandom);
      bus.pc         = $urandom;
      bus.alu_result = $urandom;
      bus.imm_ext    = $urandom;
      o_done_cyc = -1; o_wen = 0; o_fault = 0; o_waddr = 0; o_wdata = 0; o_addr = 0;
      o_addr_unstable = 0; o_early_wen = 0; o_ready_at_done = 0; o_ready_after = 0;
      req_cnt = 0; hs = 0; hs_cyc = 0;
      for (int c = 1; c <= 60; c++) begin
         if (bus.wb_done === 1'b1) begin
            o_done_cyc      = c;
            o_wen           = bus.rf_wen;
            o_waddr         = bus.rf_waddr;
            o_wdata         = bus.rf_wdata;
            o_fault         = bus.load_fault;
            o_ready_at_done = bus.in_ready;
            break;
         end
         if (bus.rf_wen === 1'b1) o_early_wen = 1;
         if (bus.mem_req_valid === 1'b1) begin
            if (req_cnt == 0) o_addr = bus.mem_addr;
            else if (bus.mem_addr !== o_addr) o_addr_unstable = 1;
            req_cnt++;
            bus.mem_req_ready = (req_cnt > req_delay);
         end else begin
            bus.mem_req_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         if (hs && c == hs_cyc + resp_delay) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = word;
         end else begin
            bus.mem_resp_valid = (noise && !hs) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_resp_data  = $urandom;
         end
         if (!hs && bus.mem_req_valid === 1'b1 && bus.mem_req_ready === 1'b1) begin
            hs = 1; hs_cyc = c;
         end
         @(negedge clk);
      end
      o_req_seen = req_cnt;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      if (o_done_cyc > 0) begin
         @(negedge clk);
         o_ready_after = bus.in_ready;
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.in_ready !== 1'b1 || bus.mem_req_valid !== 1'b0 || bus.rf_wen !== 1'b0 ||
          bus.wb_done !== 1'b0 || bus.load_fault !== 1'b0 || bus.rf_waddr !== 5'd0 ||
          bus.rf_wdata !== 32'h0 || bus.mem_addr !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got rdy=%b req=%b wen=%b done=%b flt=%b waddr=%0d wdata=%h addr=%h, expected rdy=1 and all others 0",
                  bus.in_ready, bus.mem_req_valid, bus.rf_wen, bus.wb_done, bus.load_fault,
                  bus.rf_waddr, bus.rf_wdata, bus.mem_addr);
      end
   endtask

   task automatic test_addi();
      drive_instr(1'b1, WB_ALU, 5'd5, 3'd0, 32'h100, 32'h0000_0007, 32'h55, 32'h0, 0, 1, 0);
      tests_run++;
      if (o_done_cyc !== 1 || o_wen !== 1'b1 || o_waddr !== 5'd5 || o_wdata !== 32'h7 || o_fault !== 1'b0) begin
         tests_failed++;
         $display("FAIL addi_write: got cyc=%0d wen=%b waddr=%0d wdata=%h flt=%b, expected cyc=1 wen=1 waddr=5 wdata=00000007 flt=0",
                  o_done_cyc, o_wen, o_waddr, o_wdata, o_fault);
      end
      tests_run++;
      if (o_ready_at_done !== 1'b0 || o_ready_after !== 1'b1) begin
         tests_failed++;
         $display("FAIL addi_ready: got ready T+1=%b T+2=%b, expected 0 and 1", o_ready_at_done, o_ready_after);
      end
   endtask

   task automatic test_jal_wrap();
      drive_instr(1'b1, WB_PC4, 5'd1, 3'd0, 32'hFFFF_FFFC, 32'h1234, 32'h0, 32'h0, 0, 1, 0);
      tests_run++;
      if (o_done_cyc !== 1 || o_wen !== 1'b1 || o_waddr !== 5'd1 || o_wdata !== 32'h0) begin
         tests_failed++;
         $display("FAIL jal_wrap: got cyc=%0d wen=%b waddr=%0d wdata=%h, expected cyc=1 wen=1 waddr=1 wdata=00000000",
                  o_done_cyc, o_wen, o_waddr, o_wdata);
      end
   endtask

   task automatic test_lb_lbu();
      drive_instr(1'b1, WB_MEM, 5'd9, LB, 32'h0, 32'h8000_0003, 32'h0, 32'h80FF_FF7F, 0, 1, 0);
      tests_run++;
      if (o_addr !== 32'h8000_0000 || o_done_cyc !== 3 || o_wen !== 1'b1 || o_wdata !== 32'hFFFF_FF80) begin
         tests_failed++;
         $display("FAIL lb_sign: got addr=%h cyc=%0d wen=%b wdata=%h, expected addr=80000000 cyc=3 wen=1 wdata=ffffff80",
                  o_addr, o_done_cyc, o_wen, o_wdata);
      end
      drive_instr(1'b1, WB_MEM, 5'd9, LBU, 32'h0, 32'h8000_0003, 32'h0, 32'h80FF_FF7F, 0, 1, 0);
      tests_run++;
      if (o_done_cyc !== 3 || o_wen !== 1'b1 || o_wdata !== 32'h0000_0080) begin
         tests_failed++;
         $display("FAIL lbu_zero: got cyc=%0d wen=%b wdata=%h, expected cyc=3 wen=1 wdata=00000080",
                  o_done_cyc, o_wen, o_wdata);
      end
   endtask

   task automatic test_lhu_stall();
      drive_instr(1'b1, WB_MEM, 5'd7, LHU, 32'h0, 32'h8000_0002, 32'h0, 32'hBEEF_1234, 3, 2, 0);
      tests_run++;
      if (o_addr !== 32'h8000_0000 || o_addr_unstable || o_req_seen != 4) begin
         tests_failed++;
         $display("FAIL lhu_req: got addr=%h unstable=%0d req_cycles=%0d, expected addr=80000000 unstable=0 req_cycles=4",
                  o_addr, o_addr_unstable, o_req_seen);
      end
      tests_run++;
      if (o_early_wen || o_done_cyc !== 7 || o_wen !== 1'b1 || o_waddr !== 5'd7 || o_wdata !== 32'h0000_BEEF) begin
         tests_failed++;
         $display("FAIL lhu_write: got early=%0d cyc=%0d wen=%b waddr=%0d wdata=%h, expected early=0 cyc=7 wen=1 waddr=7 wdata=0000beef",
                  o_early_wen, o_done_cyc, o_wen, o_waddr, o_wdata);
      end
   endtask

   task automatic test_fault_and_rd0();
      drive_instr(1'b1, WB_MEM, 5'd4, LW, 32'h0, 32'h8000_0002, 32'h0, 32'hDEAD_BEEF, 0, 1, 0);
      tests_run++;
      if (o_req_seen != 0 || o_done_cyc !== 1 || o_fault !== 1'b1 || o_wen !== 1'b0) begin
         tests_failed++;
         $display("FAIL lw_fault: got req_cycles=%0d cyc=%0d flt=%b wen=%b, expected 0 1 1 0",
                  o_req_seen, o_done_cyc, o_fault, o_wen);
      end
      drive_instr(1'b1, WB_IMM, 5'd0, 3'd0, 32'h0, 32'h0, 32'h1234_5000, 32'h0, 0, 1, 0);
      tests_run++;
      if (o_done_cyc !== 1 || o_wen !== 1'b0 || o_fault !== 1'b0) begin
         tests_failed++;
         $display("FAIL lui_rd0: got cyc=%0d wen=%b flt=%b, expected cyc=1 wen=0 flt=0",
                  o_done_cyc, o_wen, o_fault);
      end
   endtask

   task automatic test_back_to_back();
      longint t0;
      drive_instr(1'b1, WB_ALU, 5'd2, 3'd0, 32'h0, 32'hAAAA_0001, 32'h0, 32'h0, 0, 1, 0);
      t0 = o_accept_time;
      drive_instr(1'b1, WB_IMM, 5'd3, 3'd0, 32'h0, 32'h0, 32'h5555_0002, 32'h0, 0, 1, 0);
      tests_run++;
      if (o_accept_time - t0 != 20 || o_wen !== 1'b1 || o_waddr !== 5'd3 || o_wdata !== 32'h5555_0002) begin
         tests_failed++;
         $display("FAIL back_to_back: got spacing=%0d wen=%b waddr=%0d wdata=%h, expected spacing=20 wen=1 waddr=3 wdata=55550002",
                  o_accept_time - t0, o_wen, o_waddr, o_wdata);
      end
   endtask

   task automatic test_reset_mid_load();
      bit bad;
      for (int w = 0; w < 20 && bus.in_ready !== 1'b1; w++) @(negedge clk);
      bus.in_valid = 1'b1; bus.reg_write = 1'b1; bus.wb_sel = WB_MEM; bus.rd = 5'd3;
      bus.funct3 = LB; bus.alu_result = 32'h8000_0001;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      tests_run++;
      if (dbg_state !== ST_MEM_WAIT) begin
         tests_failed++;
         $display("FAIL reset_mid_state: got %s, expected ST_MEM_WAIT", dbg_state.name());
      end
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 4; c++) begin
         bus.mem_resp_valid = 1'b1;
         bus.mem_resp_data  = $urandom;
         @(negedge clk);
         if (bus.rf_wen !== 1'b0 || bus.wb_done !== 1'b0 || bus.in_ready !== 1'b1 ||
             bus.mem_req_valid !== 1'b0 || bus.load_fault !== 1'b0 ||
             bus.rf_wdata !== 32'h0 || bus.rf_waddr !== 5'd0 || bus.mem_addr !== 32'h0)
            bad = 1;
      end
      bus.mem_resp_valid = 1'b0;
      tests_run++;
      if (bad) begin
         tests_failed++;
         $display("FAIL reset_mid_stray_resp: got activity after reset (wen=%b done=%b rdy=%b), expected idle outputs",
                  bus.rf_wen, bus.wb_done, bus.in_ready);
      end
   endtask

   task automatic test_random();
      logic        wr;
      logic [1:0]  sel;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [31:0] pc, alu, imm, word, exp_d;
      bit          flt;
      int          rq, rs, lat;
      for (int n = 0; n < 150; n++) begin
         wr   = 1'($urandom);
         sel  = 2'($urandom);
         rd   = 5'($urandom_range(0, 31));
         f3   = 3'($urandom_range(0, 7));
         pc   = $urandom;
         alu  = $urandom;
         imm  = $urandom;
         word = $urandom;
         rq   = $urandom_range(0, 3);
         rs   = $urandom_range(1, 3);
         ref_model(sel, f3, pc, alu, imm, word, exp_d, flt);
         exp_q.push_back(exp_d);
         lat = exp_latency(sel, flt, rq, rs);
         drive_instr(wr, sel, rd, f3, pc, alu, imm, word, rq, rs, 1'b1);
         exp_d = exp_q.pop_front();
         tests_run++;
         if (o_done_cyc != lat || o_fault !== flt || o_early_wen ||
             o_wen !== (wr && rd != 0 && !flt) ||
             (o_wen === 1'b1 && (o_waddr !== rd || o_wdata !== exp_d))) begin
            tests_failed++;
            $display("FAIL rand_%0d: sel=%0d f3=%0d alu=%h got cyc=%0d flt=%b wen=%b waddr=%0d wdata=%h, expected cyc=%0d flt=%0d wen=%0d waddr=%0d wdata=%h",
                     n, sel, f3, alu, o_done_cyc, o_fault, o_wen, o_waddr, o_wdata,
                     lat, flt, (wr && rd != 0 && !flt), rd, exp_d);
         end
         if (sel == WB_MEM && !flt) begin
            tests_run++;
            if (o_addr !== {alu[31:2], 2'b00} || o_addr_unstable || o_req_seen != rq + 1) begin
               tests_failed++;
               $display("FAIL rand_req_%0d: got addr=%h unstable=%0d req_cycles=%0d, expected addr=%h unstable=0 req_cycles=%0d",
                        n, o_addr, o_addr_unstable, o_req_seen, {alu[31:2], 2'b00}, rq + 1);
            end
         end else begin
            tests_run++;
            if (o_req_seen != 0) begin
               tests_failed++;
               $display("FAIL rand_noreq_%0d: got req_cycles=%0d, expected 0", n, o_req_seen);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_jal_wrap();
      test_lb_lbu();
      test_lhu_stall();
      test_fault_and_rd0();
      test_back_to_back();
      test_reset_mid_load();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
